// File: rtl/uart_note_pkg.sv
// Shared types and sizes for the note UART link (encoder and decoder sides).
package uart_note_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam int DATA_BITS = 8;
   localparam int NOTE_W    = 7;
endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the terminal count.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clear,
   output logic tick
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk_in) begin
      if (rst_in || clear || tick) cnt <= '0;
      else                         cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/uart_note_encoder.sv
// Serialises 7-bit note codes as 8N1-style UART frames with a one-entry holding register.
module uart_note_encoder
   import uart_note_pkg::*;
#(
   parameter int   CLKS_PER_BIT = 868,
   parameter int   STOP_BITS    = 1,
   parameter logic MSB_FLAG     = 1'b0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [NOTE_W-1:0] note_in,
   input  logic              note_valid_in,
   output logic              note_ready_out,
   output logic              tx_out,
   output logic              busy_out,
   output logic              frame_done_out
);
   tx_state_t            state, state_next;
   logic [2:0]           bit_idx, bit_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic [NOTE_W-1:0]    hold_note;
   logic                 hold_valid;
   logic                 load, done, tick, clear, tx_next;

   assign note_ready_out = ~hold_valid;

   uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clear  (clear),
      .tick   (tick)
   );

   always_comb begin
      state_next = state;
      bit_next   = bit_idx;
      shift_next = shift;
      load       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (hold_valid) begin
            load       = 1'b1;
            state_next = START;
         end
         START: if (tick) begin
            state_next = DATA;
            bit_next   = '0;
         end
         DATA: if (tick) begin
            shift_next = {1'b0, shift[DATA_BITS-1:1]};
            if (bit_idx == 3'(DATA_BITS - 1)) begin
               state_next = STOP;
               bit_next   = '0;
            end else begin
               bit_next = bit_idx + 3'd1;
            end
         end
         STOP: if (tick) begin
            if (bit_idx == 3'(STOP_BITS - 1)) begin
               done = 1'b1;
               // Chain straight into the next start bit when a note is waiting.
               if (hold_valid) begin
                  load       = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               bit_next = bit_idx + 3'd1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (load) shift_next = {MSB_FLAG, hold_note};
      clear = (state_next != state) || (state == IDLE);
      case (state)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift[0];
         default: tx_next = 1'b1;
      endcase
   end

   // Line outputs are registered, so the pin lags the FSM by one cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= IDLE;
         bit_idx        <= '0;
         shift          <= '0;
         hold_note      <= '0;
         hold_valid     <= 1'b0;
         tx_out         <= 1'b1;
         busy_out       <= 1'b0;
         frame_done_out <= 1'b0;
      end else begin
         state          <= state_next;
         bit_idx        <= bit_next;
         shift          <= shift_next;
         tx_out         <= tx_next;
         busy_out       <= (state != IDLE);
         frame_done_out <= done;
         if (load) begin
            hold_valid <= 1'b0;
         end else if (note_valid_in && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_note  <= note_in;
         end
      end
   end
endmodule

// File: tb/tb_uart_note_encoder.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes and compares frames.
module tb_uart_note_encoder;
   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [6:0] note_in = '0;
   logic       note_valid_in = 1'b0;
   logic       note_ready_out, tx_out, busy_out, frame_done_out;
   logic [6:0] f_note = '0;
   logic       f_valid = 1'b0;
   logic       f_ready, f_tx, f_busy, f_done;

   int checks = 0, failures = 0;
   logic [7:0] exp_q[$];

   always #5 clk_in = ~clk_in;

   uart_note_encoder #(.CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FLAG(1'b0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .note_in(note_in), .note_valid_in(note_valid_in),
      .note_ready_out(note_ready_out), .tx_out(tx_out), .busy_out(busy_out),
      .frame_done_out(frame_done_out));

   uart_note_encoder #(.CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FLAG(1'b1)) dut_flag (
      .clk_in(clk_in), .rst_in(rst_in), .note_in(f_note), .note_valid_in(f_valid),
      .note_ready_out(f_ready), .tx_out(f_tx), .busy_out(f_busy), .frame_done_out(f_done));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Line monitor: one frame is 40 cycles at 4 clocks per bit.
   logic       mon_active = 1'b0;
   int         mon_c = 0, tx_err = 0, busy_err = 0, done_err = 0;
   int         stray_busy = 0, stray_done = 0, frames_done = 0;
   logic [7:0] mon_exp = '0, mon_got = '0;

   always @(negedge clk_in) begin
      if (rst_in) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && !tx_out) begin
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 1, 0);
               mon_exp = '0;
            end else begin
               mon_exp = exp_q.pop_front();
            end
            mon_active = 1'b1;
            mon_c = 0; tx_err = 0; busy_err = 0; done_err = 0; mon_got = '0;
         end
         if (mon_active) begin
            automatic int  b   = mon_c / 4;
            automatic logic lvl = (b == 0) ? 1'b0 : (b <= 8) ? mon_exp[b-1] : 1'b1;
            if (tx_out !== lvl) tx_err++;
            if (b >= 1 && b <= 8 && (mon_c % 4) == 2) mon_got[b-1] = tx_out;
            if (busy_out !== 1'b1) busy_err++;
            if (frame_done_out !== (mon_c == 39)) done_err++;
            mon_c++;
            if (mon_c == 40) begin
               check("frame_data", int'(mon_got), int'(mon_exp));
               check("frame_line_errors", tx_err, 0);
               check("frame_busy_errors", busy_err, 0);
               check("frame_done_errors", done_err, 0);
               frames_done++;
               mon_active = 1'b0;
            end
         end else begin
            if (busy_out) stray_busy++;
            if (frame_done_out) stray_done++;
         end
      end
   end

   task automatic send(input logic [6:0] n);
      bit r;
      int t = 0;
      @(negedge clk_in);
      note_in = n; note_valid_in = 1'b1;
      do begin
         r = note_ready_out;
         @(posedge clk_in);
         t++;
      end while (!r && t < 500);
      if (r) exp_q.push_back({1'b0, n});
      else   check("send_timeout", 0, 1);
      #1 note_valid_in = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      repeat (3) @(negedge clk_in);
      while ((busy_out || !note_ready_out) && n < 1000) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 1000) check("idle_timeout", 0, 1);
      repeat (2) @(negedge clk_in);
   endtask

   task automatic busy_len(output int len);
      int n = 0;
      len = 0;
      while (!busy_out && n < 20) begin
         @(negedge clk_in);
         n++;
      end
      while (busy_out && len < 500) begin
         len++;
         @(negedge clk_in);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, len, leak, fd;
      logic [7:0] got;
      logic stop_lvl;

      // Reset
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("reset_tx", tx_out, 1);
      check("reset_busy", busy_out, 0);
      check("reset_ready", note_ready_out, 1);
      check("reset_done", frame_done_out, 0);
      rst_in = 1'b0;
      repeat (2) @(negedge clk_in);

      // Single note: latency and busy width
      send(7'h25);
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (tx_out && n < 10);
      check("start_latency_edges", n - 1, 2);
      len = 1;
      while (busy_out && len < 500) begin
         @(negedge clk_in);
         if (busy_out) len++;
         else break;
      end
      check("single_busy_cycles", len, 40);
      wait_idle();

      // Back-to-back frames with no idle gap
      send(7'h01);
      send(7'h7F);
      busy_len(len);
      check("b2b_busy_cycles", len, 80);
      wait_idle();

      // Backpressure: holding register full, producer keeps offering
      send(7'h11);
      send(7'h22);
      @(negedge clk_in);
      note_in = 7'h33; note_valid_in = 1'b1;
      leak = 0;
      repeat (20) begin
         @(negedge clk_in);
         if (note_ready_out) leak++;
      end
      check("backpressure_ready_low", leak, 0);
      send(7'h5A);
      wait_idle();

      // Rest note with the flag bit set
      @(negedge clk_in);
      check("flag_ready", f_ready, 1);
      f_note = 7'h00; f_valid = 1'b1;
      @(posedge clk_in);
      #1 f_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (f_tx && n < 20);
      check("flag_start_seen", f_tx, 0);
      got = '0; stop_lvl = 1'b0; fd = 0;
      for (int c = 1; c < 40; c++) begin
         @(negedge clk_in);
         if ((c % 4) == 2 && c / 4 >= 1 && c / 4 <= 8) got[c/4-1] = f_tx;
         if (c == 38) stop_lvl = f_tx;
         if (f_done) fd++;
      end
      check("flag_data", got, 8'h80);
      check("flag_stop", stop_lvl, 1);
      check("flag_done_pulses", fd, 1);
      wait_idle();

      // Reset during data bit 3
      send(7'h55);
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (tx_out && n < 10);
      repeat (17) @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      check("midreset_tx", tx_out, 1);
      check("midreset_busy", busy_out, 0);
      check("midreset_done", frame_done_out, 0);
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      repeat (10) @(negedge clk_in);
      send(7'h2A);
      wait_idle();

      check("queue_drained", exp_q.size(), 0);
      check("frames_completed", frames_done, 7);
      check("stray_busy", stray_busy, 0);
      check("stray_done", stray_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
